// File: rtl/ace_fetch_pkg.sv
// Shared types and constants for the ace fetch/issue stage.
package ace_fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 8;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned LINE_BYTES  = 32;
  localparam int unsigned OFFSET_W    = $clog2(FETCH_WIDTH);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_e;

  typedef logic [FETCH_WIDTH-1:0][INST_W-1:0] bundle_t;
  typedef logic [FETCH_WIDTH-1:0]             slot_mask_t;

endpackage

// File: rtl/ace_fetch_issue_if.sv
// Redirect, I-cache and decode-side signals of the fetch/issue stage.
interface ace_fetch_issue_if;
  logic         redirect_vld_i;
  logic [63:0]  redirect_pc_i;
  logic         icache_req_vld_o;
  logic [63:0]  icache_req_pc_o;
  logic         icache_req_rdy_i;
  logic         icache_rsp_vld_i;
  logic [255:0] icache_rsp_data_i;
  logic         instbuf_full_i;
  logic         pipe_load_decode_o;
  logic [31:0]  fetch_inst0_o, fetch_inst1_o, fetch_inst2_o, fetch_inst3_o;
  logic [31:0]  fetch_inst4_o, fetch_inst5_o, fetch_inst6_o, fetch_inst7_o;
  logic         fetch_inst0_vld_o, fetch_inst1_vld_o, fetch_inst2_vld_o, fetch_inst3_vld_o;
  logic         fetch_inst4_vld_o, fetch_inst5_vld_o, fetch_inst6_vld_o, fetch_inst7_vld_o;
  logic [63:0]  fetch_pc_o;

  modport master (
    input  redirect_vld_i, redirect_pc_i, icache_req_rdy_i, icache_rsp_vld_i,
           icache_rsp_data_i, instbuf_full_i,
    output icache_req_vld_o, icache_req_pc_o, pipe_load_decode_o, fetch_pc_o,
           fetch_inst0_o, fetch_inst1_o, fetch_inst2_o, fetch_inst3_o,
           fetch_inst4_o, fetch_inst5_o, fetch_inst6_o, fetch_inst7_o,
           fetch_inst0_vld_o, fetch_inst1_vld_o, fetch_inst2_vld_o, fetch_inst3_vld_o,
           fetch_inst4_vld_o, fetch_inst5_vld_o, fetch_inst6_vld_o, fetch_inst7_vld_o
  );

  modport slave (
    output redirect_vld_i, redirect_pc_i, icache_req_rdy_i, icache_rsp_vld_i,
           icache_rsp_data_i, instbuf_full_i,
    input  icache_req_vld_o, icache_req_pc_o, pipe_load_decode_o, fetch_pc_o,
           fetch_inst0_o, fetch_inst1_o, fetch_inst2_o, fetch_inst3_o,
           fetch_inst4_o, fetch_inst5_o, fetch_inst6_o, fetch_inst7_o,
           fetch_inst0_vld_o, fetch_inst1_vld_o, fetch_inst2_vld_o, fetch_inst3_vld_o,
           fetch_inst4_vld_o, fetch_inst5_vld_o, fetch_inst6_vld_o, fetch_inst7_vld_o
  );
endinterface

// File: rtl/fetch_vld_mask.sv
// Maps the in-line word offset of the fetch PC to the valid-slot mask:
// slot N is valid when N >= offset.
module fetch_vld_mask
  import ace_fetch_pkg::*;
(
  input  logic [OFFSET_W-1:0] offset_i,
  output slot_mask_t          mask_o
);

  slot_mask_t all_ones;

  always_comb begin
    all_ones = '1;
    mask_o   = all_ones << offset_i;
  end

endmodule

// File: rtl/ace_fetch_issue.sv
// Fetch/issue stage: requests one 32-byte I-cache line at a time, holds the
// returned bundle until decode accepts it, and handles retire redirects.
module ace_fetch_issue
  import ace_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clock,
  input  logic               reset_n,
  ace_fetch_issue_if.master  bus
);

  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  slot_mask_t   vld_q, vld_d;
  bundle_t      bundle_q, bundle_d;
  logic         req_vld_q, req_vld_d;
  logic         load;
  slot_mask_t   slot_mask;

  fetch_vld_mask u_vld_mask (
    .offset_i (pc_q[4:2]),
    .mask_o   (slot_mask)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    bundle_d = bundle_q;
    load     = 1'b0;

    if (bus.redirect_vld_i) begin
      // Redirect wins over every other event; a request still in flight must be drained.
      pc_d  = bus.redirect_pc_i & ~64'h3;
      vld_d = '0;
      unique case (state_q)
        ST_REQ:   state_d = (req_vld_q && bus.icache_req_rdy_i) ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = bus.icache_rsp_vld_i ? ST_REQ : ST_DRAIN;
        ST_HOLD:  state_d = ST_REQ;
        ST_DRAIN: state_d = bus.icache_rsp_vld_i ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (req_vld_q && bus.icache_req_rdy_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.icache_rsp_vld_i) begin
            bundle_d = bus.icache_rsp_data_i;
            vld_d    = slot_mask;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!bus.instbuf_full_i) begin
            load    = 1'b1;
            pc_d    = (pc_q & LINE_MASK) + 64'(LINE_BYTES);
            vld_d   = '0;
            state_d = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.icache_rsp_vld_i) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end

    // The request valid is registered so it stays low throughout reset.
    req_vld_d = (state_d == ST_REQ);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      vld_q     <= '0;
      req_vld_q <= 1'b0;
      // NOTE: the bundle register is reset because its contents are visible on the outputs.
      bundle_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      vld_q     <= vld_d;
      req_vld_q <= req_vld_d;
      bundle_q  <= bundle_d;
    end
  end

  assign bus.icache_req_vld_o   = req_vld_q;
  assign bus.icache_req_pc_o    = pc_q & LINE_MASK;
  assign bus.pipe_load_decode_o = load;
  assign bus.fetch_pc_o         = pc_q;

  assign bus.fetch_inst0_o = bundle_q[0];
  assign bus.fetch_inst1_o = bundle_q[1];
  assign bus.fetch_inst2_o = bundle_q[2];
  assign bus.fetch_inst3_o = bundle_q[3];
  assign bus.fetch_inst4_o = bundle_q[4];
  assign bus.fetch_inst5_o = bundle_q[5];
  assign bus.fetch_inst6_o = bundle_q[6];
  assign bus.fetch_inst7_o = bundle_q[7];

  assign bus.fetch_inst0_vld_o = vld_q[0];
  assign bus.fetch_inst1_vld_o = vld_q[1];
  assign bus.fetch_inst2_vld_o = vld_q[2];
  assign bus.fetch_inst3_vld_o = vld_q[3];
  assign bus.fetch_inst4_vld_o = vld_q[4];
  assign bus.fetch_inst5_vld_o = vld_q[5];
  assign bus.fetch_inst6_vld_o = vld_q[6];
  assign bus.fetch_inst7_vld_o = vld_q[7];

endmodule

// File: tb/tb_ace_fetch_issue.sv
// Directed bench for ace_fetch_issue: reset, line fetch, redirects, back-pressure, PC wrap.
module tb_ace_fetch_issue;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  ace_fetch_issue_if ifc ();

  ace_fetch_issue #(.RESET_PC(64'h100)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] vld_vec;
  assign vld_vec = {ifc.fetch_inst7_vld_o, ifc.fetch_inst6_vld_o, ifc.fetch_inst5_vld_o,
                    ifc.fetch_inst4_vld_o, ifc.fetch_inst3_vld_o, ifc.fetch_inst2_vld_o,
                    ifc.fetch_inst1_vld_o, ifc.fetch_inst0_vld_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] make_bundle(input logic [31:0] base);
    logic [255:0] b;
    for (int n = 0; n < 8; n++) b[32*n +: 32] = base + 32'(n);
    return b;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    ifc.redirect_vld_i    = 1'b0;
    ifc.redirect_pc_i     = '0;
    ifc.icache_req_rdy_i  = 1'b0;
    ifc.icache_rsp_vld_i  = 1'b0;
    ifc.icache_rsp_data_i = '0;
    ifc.instbuf_full_i    = 1'b0;
    tick();
    tick();

    check("rst_req_vld", 64'(ifc.icache_req_vld_o), 64'd0);
    check("rst_fetch_pc", ifc.fetch_pc_o, 64'h100);
    check("rst_vld", 64'(vld_vec), 64'h0);
    check("rst_load", 64'(ifc.pipe_load_decode_o), 64'd0);
    check("rst_inst0", 64'(ifc.fetch_inst0_o), 64'h0);

    // Basic line fetch from RESET_PC
    reset_n = 1'b1;
    tick();
    check("req_vld", 64'(ifc.icache_req_vld_o), 64'd1);
    check("req_pc", ifc.icache_req_pc_o, 64'h100);
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i = 1'b0;
    check("wait_req_vld", 64'(ifc.icache_req_vld_o), 64'd0);
    ifc.icache_rsp_vld_i  = 1'b1;
    ifc.icache_rsp_data_i = make_bundle(32'hA0);
    tick();
    ifc.icache_rsp_vld_i = 1'b0;
    check("hold_vld", 64'(vld_vec), 64'hFF);
    check("hold_pc", ifc.fetch_pc_o, 64'h100);
    check("hold_inst0", 64'(ifc.fetch_inst0_o), 64'hA0);
    check("hold_inst7", 64'(ifc.fetch_inst7_o), 64'hA7);
    check("hold_load", 64'(ifc.pipe_load_decode_o), 64'd1);
    tick();
    check("next_req_pc", ifc.icache_req_pc_o, 64'h120);
    check("next_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);
    check("next_vld", 64'(vld_vec), 64'h0);
    check("next_load", 64'(ifc.pipe_load_decode_o), 64'd0);

    // Redirect to mid-line PC, then back-pressure in HOLD
    ifc.redirect_vld_i = 1'b1;
    ifc.redirect_pc_i  = 64'h1234;
    tick();
    ifc.redirect_vld_i = 1'b0;
    check("redir_req_pc", ifc.icache_req_pc_o, 64'h1220);
    check("redir_fetch_pc", ifc.fetch_pc_o, 64'h1234);
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i  = 1'b0;
    ifc.icache_rsp_vld_i  = 1'b1;
    ifc.icache_rsp_data_i = make_bundle(32'hB0);
    ifc.instbuf_full_i    = 1'b1;
    tick();
    ifc.icache_rsp_vld_i = 1'b0;
    check("redir_mask", 64'(vld_vec), 64'hE0);
    check("redir_hold_pc", ifc.fetch_pc_o, 64'h1234);
    check("redir_inst5", 64'(ifc.fetch_inst5_o), 64'hB5);
    for (int i = 0; i < 10; i++) begin
      check("full_load", 64'(ifc.pipe_load_decode_o), 64'd0);
      check("full_req_vld", 64'(ifc.icache_req_vld_o), 64'd0);
      check("full_vld", 64'(vld_vec), 64'hE0);
      check("full_inst5", 64'(ifc.fetch_inst5_o), 64'hB5);
      tick();
    end
    ifc.instbuf_full_i = 1'b0;
    #1;
    check("unfull_load", 64'(ifc.pipe_load_decode_o), 64'd1);
    tick();
    check("unfull_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);
    check("unfull_req_pc", ifc.icache_req_pc_o, 64'h1240);
    check("unfull_vld", 64'(vld_vec), 64'h0);

    // Redirect in WAIT, stale response three cycles later
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i = 1'b0;
    ifc.redirect_vld_i   = 1'b1;
    ifc.redirect_pc_i    = 64'h2000;
    tick();
    ifc.redirect_vld_i = 1'b0;
    check("drain_req_vld", 64'(ifc.icache_req_vld_o), 64'd0);
    check("drain_fetch_pc", ifc.fetch_pc_o, 64'h2000);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        ifc.icache_rsp_vld_i  = 1'b1;
        ifc.icache_rsp_data_i = make_bundle(32'hC0);
      end
      tick();
      ifc.icache_rsp_vld_i = 1'b0;
      check("drain_vld", 64'(vld_vec), 64'h0);
    end
    check("drain_req_vld_after", 64'(ifc.icache_req_vld_o), 64'd1);
    check("drain_req_pc_after", ifc.icache_req_pc_o, 64'h2000);
    check("stale_inst0", 64'(ifc.fetch_inst0_o), 64'hB0);

    // Redirect coincident with a load in HOLD
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i  = 1'b0;
    ifc.icache_rsp_vld_i  = 1'b1;
    ifc.icache_rsp_data_i = make_bundle(32'hD0);
    tick();
    ifc.icache_rsp_vld_i = 1'b0;
    check("h2_vld", 64'(vld_vec), 64'hFF);
    ifc.redirect_vld_i = 1'b1;
    ifc.redirect_pc_i  = 64'h3008;
    #1;
    check("redir_load_blocked", 64'(ifc.pipe_load_decode_o), 64'd0);
    tick();
    ifc.redirect_vld_i = 1'b0;
    check("h2_req_pc", ifc.icache_req_pc_o, 64'h3000);
    check("h2_fetch_pc", ifc.fetch_pc_o, 64'h3008);
    check("h2_vld_clear", 64'(vld_vec), 64'h0);
    check("h2_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);

    // Redirect in WAIT coincident with the response: response dropped
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i  = 1'b0;
    ifc.redirect_vld_i    = 1'b1;
    ifc.redirect_pc_i     = 64'h4000;
    ifc.icache_rsp_vld_i  = 1'b1;
    ifc.icache_rsp_data_i = make_bundle(32'hE0);
    tick();
    ifc.redirect_vld_i   = 1'b0;
    ifc.icache_rsp_vld_i = 1'b0;
    check("coin_vld", 64'(vld_vec), 64'h0);
    check("coin_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);
    check("coin_req_pc", ifc.icache_req_pc_o, 64'h4000);
    check("coin_inst0", 64'(ifc.fetch_inst0_o), 64'hD0);

    // Reset mid-WAIT
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i = 1'b0;
    reset_n = 1'b0;
    tick();
    check("mid_rst_req_vld", 64'(ifc.icache_req_vld_o), 64'd0);
    check("mid_rst_fetch_pc", ifc.fetch_pc_o, 64'h100);
    check("mid_rst_vld", 64'(vld_vec), 64'h0);
    check("mid_rst_load", 64'(ifc.pipe_load_decode_o), 64'd0);
    check("mid_rst_inst0", 64'(ifc.fetch_inst0_o), 64'h0);
    reset_n = 1'b1;
    tick();
    check("restart_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);
    check("restart_req_pc", ifc.icache_req_pc_o, 64'h100);

    // PC wrap at the top of the address space
    ifc.redirect_vld_i = 1'b1;
    ifc.redirect_pc_i  = 64'hFFFF_FFFF_FFFF_FFE7;
    tick();
    ifc.redirect_vld_i = 1'b0;
    check("wrap_fetch_pc", ifc.fetch_pc_o, 64'hFFFF_FFFF_FFFF_FFE4);
    ifc.icache_req_rdy_i = 1'b1;
    tick();
    ifc.icache_req_rdy_i  = 1'b0;
    ifc.icache_rsp_vld_i  = 1'b1;
    ifc.icache_rsp_data_i = make_bundle(32'hF0);
    tick();
    ifc.icache_rsp_vld_i = 1'b0;
    check("wrap_mask", 64'(vld_vec), 64'hFE);
    check("wrap_load", 64'(ifc.pipe_load_decode_o), 64'd1);
    tick();
    check("wrap_req_pc", ifc.icache_req_pc_o, 64'h0);
    check("wrap_req_vld", 64'(ifc.icache_req_vld_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ace_fetch_issue.md
ACE_FETCH_ISSUE -- requirements
Module: ace_fetch_issue

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the first fetch PC after reset (bits [1:0] zero).
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 redirect_vld_i  in  1  retire flush/redirect strobe.
REQ-005 redirect_pc_i  in  64  new fetch PC; bits [1:0] ignored.
REQ-006 icache_req_vld_o  out  1  I-cache line request valid.
REQ-007 icache_req_pc_o  out  64  request address, always 32-byte aligned ({pc[63:5],5'b0}).
REQ-008 icache_req_rdy_i  in  1  request accepted when vld&&rdy.
REQ-009 icache_rsp_vld_i  in  1  one-cycle strobe; response data valid.
REQ-010 icache_rsp_data_i  in  256  eight instructions; slot N = bits [32N+31:32N].
REQ-011 instbuf_full_i  in  1  decode instruction buffer cannot accept a bundle.
REQ-012 pipe_load_decode_o  out  1  bundle transferred to decode this cycle.
REQ-013 fetch_inst0_o..fetch_inst7_o  out  32 each  held bundle instructions.
REQ-014 fetch_inst0_vld_o..fetch_inst7_vld_o  out  1 each  per-slot valid.
REQ-015 fetch_pc_o  out  64  PC of the held bundle (first valid slot).

Function
REQ-016 States SHALL be REQ, WAIT, HOLD, DRAIN; at most one I-cache request is outstanding.
REQ-017 REQ: icache_req_vld_o=1; on icache_req_rdy_i go to WAIT.
REQ-018 WAIT: on icache_rsp_vld_i, capture data into the bundle register and go to HOLD; bundle outputs are valid the following cycle (1-cycle latency).
REQ-019 Slot N valid iff N >= pc[4:2] (e.g. pc[4:2]=3 gives mask 8'b1111_1000, slot 0 = LSB).
REQ-020 HOLD: pipe_load_decode_o = !instbuf_full_i; only in HOLD can it be 1; bundle and valids are stable while held.
REQ-021 On load, pc <= {pc[63:5]+1, 5'b0}, valids clear, next state REQ; pc wraps modulo 2^64.
REQ-022 Outside HOLD all fetch_instN_vld_o SHALL be 0; fetch_instN_o keep last captured data.
REQ-023 redirect_vld_i has priority over all other events in every state: pc <= {redirect_pc_i[63:2],2'b00}, valids clear, pipe_load_decode_o forced 0 that cycle.
REQ-024 Redirect next state: DRAIN if a request is outstanding after this edge (state WAIT without icache_rsp_vld_i, or REQ with icache_req_rdy_i), else REQ.
REQ-025 Redirect in WAIT coincident with icache_rsp_vld_i: response discarded, next state REQ.
REQ-026 DRAIN: icache_req_vld_o=0; on icache_rsp_vld_i discard data, go to REQ; redirect in DRAIN updates pc and stays DRAIN unless the response arrives same cycle (then REQ).
REQ-027 instbuf_full_i held indefinitely SHALL keep HOLD with no new requests and no data loss.

Reset
REQ-028 While reset_n=0 at an edge: state<=REQ, pc<=RESET_PC, all valids and pipe_load_decode_o 0, icache_req_vld_o 0 (registered), bundle data 0, fetch_pc_o RESET_PC.
REQ-029 Reset asserted mid-WAIT abandons the request; the I-cache is reset concurrently, so no DRAIN is needed.

Structure
REQ-030 Shared package ace_fetch_pkg SHALL hold the state enum, FETCH_WIDTH=8, INST_W=32, LINE_BYTES=32.
REQ-031 One sub-module, fetch_vld_mask, SHALL map the 3-bit offset pc[4:2] to the 8-bit slot-valid mask.

Verification
REQ-032 Reset with RESET_PC=64'h100; req accepted, rsp data slots = 32'hA0..A7 -> next cycle all 8 valid, fetch_pc_o=64'h100, load fires, next request PC 64'h120.
REQ-033 Redirect to 64'h1234 -> icache_req_pc_o=64'h1220, mask 8'b1110_0000, fetch_pc_o=64'h1234.
REQ-034 instbuf_full_i=1 for 10 cycles in HOLD -> no load, no request, outputs stable; full drops -> load in that cycle, request next cycle.
REQ-035 Redirect to 64'h2000 in WAIT, stale rsp 3 cycles later -> stale data never valid; next request PC 64'h2000.
REQ-036 Redirect coincident with load in HOLD -> pipe_load_decode_o=0, next request PC = redirect target.
REQ-037 reset_n low mid-WAIT -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
